// File: rtl/top_simple_cpu.sv
`default_nettype none
// ============================================================================
// Module   : top_simple_cpu
// Brief    : Slice-based ALU execute stage (ADD/SHR/POPCNT/CMP), 1-cycle
//            registered outputs. Optional COUT port: TOP_SIMPLE_CPU_COUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module top_simple_cpu_slice #(
    parameter int S = 4
) (
    input  logic [S-1:0]           i_a,
    input  logic [S-1:0]           i_b,
    input  logic                   i_cin,
    input  logic                   i_shr_in,
    output logic [S-1:0]           o_sum,
    output logic                   o_cout,
    output logic [S-1:0]           o_shr,
    output logic [$clog2(S+1)-1:0] o_pop,
    output logic                   o_gt,
    output logic                   o_lt
);
    localparam int c_PW = $clog2(S + 1);

    logic [S:0] w_sum_ext;

    assign w_sum_ext = {1'b0, i_a} + {1'b0, i_b} + {{S{1'b0}}, i_cin};
    assign o_sum     = w_sum_ext[S-1:0];
    assign o_cout    = w_sum_ext[S];

    // The bit entering the slice MSB comes from the next-higher slice
    assign o_shr = {i_shr_in, i_a[S-1:1]};

    always_comb begin
        o_pop = '0;
        for (int k = 0; k < S; k++) begin
            o_pop = o_pop + c_PW'(i_a[k]);
        end
    end

    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);

endmodule

module top_simple_cpu #(
    parameter int S   = 4,
    parameter int N_A = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S*N_A-1:0]   A,
    input  logic [S*N_A-1:0]   B,
    input  logic [2:0]         op,
`ifdef TOP_SIMPLE_CPU_COUT_EN
    output logic               COUT,
`endif
    output logic [S*N_A-1:0]   RESULT,
    output logic [1:0]         CMP
);
    localparam int c_W  = S * N_A;
    localparam int c_PW = $clog2(S + 1);
    localparam int c_CW = $clog2(c_W + 1);

    localparam logic [2:0] c_OP_ADD    = 3'b000;
    localparam logic [2:0] c_OP_SHR    = 3'b001;
    localparam logic [2:0] c_OP_POPCNT = 3'b010;
    localparam logic [2:0] c_OP_CMP    = 3'b011;

    logic [c_W-1:0]  w_add;
    logic [c_W-1:0]  w_shr;
    logic [c_CW-1:0] w_pop_total;
    logic            w_add_cout;
    logic            w_a_gt_b;
    logic            w_a_lt_b;

    logic [c_W-1:0]  w_result;
    logic [1:0]      w_cmp;
    logic            w_cout;

    logic [c_W-1:0]  r_result;
    logic [1:0]      r_cmp;

    genvar gi;
    generate
        for (gi = 0; gi < N_A; gi++) begin : g_slice
            logic            w_cin;
            logic            w_shr_in;
            logic            w_cout;
            logic [c_PW-1:0] w_pop;
            logic [c_CW-1:0] w_pop_acc;
            logic            w_gt;
            logic            w_lt;
            logic            w_gt_acc;
            logic            w_lt_acc;

            if (gi == 0) begin : g_first
                assign w_cin     = 1'b0;
                assign w_pop_acc = c_CW'(w_pop);
            end else begin : g_rest
                assign w_cin     = g_slice[gi-1].w_cout;
                assign w_pop_acc = g_slice[gi-1].w_pop_acc + c_CW'(w_pop);
            end

            // Compare resolves top-down: a higher unequal slice wins
            if (gi == N_A - 1) begin : g_top
                assign w_shr_in = 1'b0;
                assign w_gt_acc = w_gt;
                assign w_lt_acc = w_lt;
            end else begin : g_low
                assign w_shr_in = A[(gi+1)*S];
                assign w_gt_acc = (g_slice[gi+1].w_gt_acc | g_slice[gi+1].w_lt_acc)
                                  ? g_slice[gi+1].w_gt_acc : w_gt;
                assign w_lt_acc = (g_slice[gi+1].w_gt_acc | g_slice[gi+1].w_lt_acc)
                                  ? g_slice[gi+1].w_lt_acc : w_lt;
            end

            top_simple_cpu_slice #(
                .S (S)
            ) u_slice (
                .i_a      (A[gi*S +: S]),
                .i_b      (B[gi*S +: S]),
                .i_cin    (w_cin),
                .i_shr_in (w_shr_in),
                .o_sum    (w_add[gi*S +: S]),
                .o_cout   (w_cout),
                .o_shr    (w_shr[gi*S +: S]),
                .o_pop    (w_pop),
                .o_gt     (w_gt),
                .o_lt     (w_lt)
            );
        end
    endgenerate

    assign w_add_cout  = g_slice[N_A-1].w_cout;
    assign w_pop_total = g_slice[N_A-1].w_pop_acc;
    assign w_a_gt_b    = g_slice[0].w_gt_acc;
    assign w_a_lt_b    = g_slice[0].w_lt_acc;

    always_comb begin
        w_result = '0;
        w_cmp    = 2'b00;
        w_cout   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_result = w_add;
                w_cout   = w_add_cout;
            end
            c_OP_SHR: begin
                w_result = w_shr;
                w_cout   = A[0];
            end
            c_OP_POPCNT: begin
                w_result = c_W'(w_pop_total);
            end
            c_OP_CMP: begin
                if (w_a_gt_b) begin
                    w_cmp = 2'b01;
                end else if (w_a_lt_b) begin
                    w_cmp = 2'b10;
                end
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_cmp    <= 2'b00;
        end else begin
            r_result <= w_result;
            r_cmp    <= w_cmp;
        end
    end

    assign RESULT = r_result;
    assign CMP    = r_cmp;

`ifdef TOP_SIMPLE_CPU_COUT_EN
    logic r_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cout <= 1'b0;
        end else begin
            r_cout <= w_cout;
        end
    end

    assign COUT = r_cout;
`else
    logic w_unused_cout;
    assign w_unused_cout = w_cout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_top_simple_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_simple_cpu
// Brief    : Directed self-checking bench for top_simple_cpu (W=8 default).
// Revision : 1.0 - initial release
// ============================================================================

module tb_top_simple_cpu;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic [7:0] RESULT;
    logic [1:0] CMP;
`ifdef TOP_SIMPLE_CPU_COUT_EN
    logic       COUT;
`endif

    int n_assert;
    int n_fail;

    top_simple_cpu #(
        .S   (4),
        .N_A (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .op     (op),
`ifdef TOP_SIMPLE_CPU_COUT_EN
        .COUT   (COUT),
`endif
        .RESULT (RESULT),
        .CMP    (CMP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp_res,
                         input logic [1:0] exp_cmp, input logic exp_cout);
        n_assert++;
        assert (RESULT === exp_res)
        else begin
            n_fail++;
            $error("FAIL %s RESULT observed=%0d expected=%0d", tag, RESULT, exp_res);
        end
        n_assert++;
        assert (CMP === exp_cmp)
        else begin
            n_fail++;
            $error("FAIL %s CMP observed=%b expected=%b", tag, CMP, exp_cmp);
        end
`ifdef TOP_SIMPLE_CPU_COUT_EN
        n_assert++;
        assert (COUT === exp_cout)
        else begin
            n_fail++;
            $error("FAIL %s COUT observed=%b expected=%b", tag, COUT, exp_cout);
        end
`else
        if (exp_cout === 1'bx) n_assert = n_assert + 0;
`endif
    endtask

    // Apply inputs away from the edge, then sample just after the capturing edge
    task automatic step(input logic rstn, input logic [2:0] o,
                        input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst_n = rstn;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        op       = 3'b000;
        A        = 8'd0;
        B        = 8'd0;

        step(1'b0, 3'b000, 8'd10, 8'd22);
        check("reset_edge1", 8'd0, 2'b00, 1'b0);
        step(1'b0, 3'b000, 8'd10, 8'd22);
        check("reset_edge2", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b000, 8'd10, 8'd22);
        check("reset_release_add", 8'd32, 2'b00, 1'b0);

        step(1'b1, 3'b000, 8'd255, 8'd1);
        check("add_wrap", 8'd0, 2'b00, 1'b1);
        step(1'b1, 3'b000, 8'd100, 8'd50);
        check("add_100_50", 8'd150, 2'b00, 1'b0);
        step(1'b1, 3'b000, 8'd15, 8'd1);
        check("add_slice_carry", 8'd16, 2'b00, 1'b0);

        step(1'b1, 3'b001, 8'b10110011, 8'h00);
        check("shr_b3", 8'd89, 2'b00, 1'b1);
        step(1'b1, 3'b001, 8'd1, 8'h00);
        check("shr_one", 8'd0, 2'b00, 1'b1);
        step(1'b1, 3'b001, 8'b10110011, 8'hFF);
        check("shr_ignore_b", 8'd89, 2'b00, 1'b1);
        step(1'b1, 3'b001, 8'h10, 8'h00);
        check("shr_cross_slice", 8'h08, 2'b00, 1'b0);
        step(1'b1, 3'b001, 8'h80, 8'h00);
        check("shr_msb_zero_fill", 8'h40, 2'b00, 1'b0);

        step(1'b1, 3'b010, 8'h00, 8'hFF);
        check("pop_zero", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b010, 8'hFF, 8'h00);
        check("pop_all", 8'd8, 2'b00, 1'b0);
        step(1'b1, 3'b010, 8'b10101101, 8'h00);
        check("pop_ad", 8'd5, 2'b00, 1'b0);

        step(1'b1, 3'b011, 8'd50, 8'd50);
        check("cmp_eq", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b011, 8'd200, 8'd100);
        check("cmp_gt_unsigned", 8'd0, 2'b01, 1'b0);
        step(1'b1, 3'b011, 8'd10, 8'd20);
        check("cmp_lt", 8'd0, 2'b10, 1'b0);
        step(1'b1, 3'b011, 8'h80, 8'h7F);
        check("cmp_top_slice_gt", 8'd0, 2'b01, 1'b0);
        step(1'b1, 3'b011, 8'h17, 8'h18);
        check("cmp_low_slice_lt", 8'd0, 2'b10, 1'b0);
        step(1'b1, 3'b011, 8'h1F, 8'h20);
        check("cmp_top_overrides_low", 8'd0, 2'b10, 1'b0);

        step(1'b1, 3'b000, 8'd3, 8'd4);
        check("b2b_add", 8'd7, 2'b00, 1'b0);
        step(1'b1, 3'b011, 8'd1, 8'd2);
        check("b2b_cmp", 8'd0, 2'b10, 1'b0);
        step(1'b1, 3'b010, 8'h0F, 8'h00);
        check("b2b_pop", 8'd4, 2'b00, 1'b0);
        step(1'b1, 3'b111, 8'hFF, 8'hFF);
        check("b2b_rsvd_111", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b100, 8'd9, 8'd9);
        check("rsvd_100", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b101, 8'h01, 8'h02);
        check("rsvd_101", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b110, 8'hFF, 8'h01);
        check("rsvd_110", 8'd0, 2'b00, 1'b0);

        step(1'b1, 3'b000, 8'd200, 8'd10);
        check("pre_reset_add", 8'd210, 2'b00, 1'b0);
        step(1'b0, 3'b000, 8'd255, 8'd1);
        check("reset_priority", 8'd0, 2'b00, 1'b0);
        step(1'b1, 3'b011, 8'd7, 8'd3);
        check("post_reset_cmp", 8'd0, 2'b01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_simple_cpu.md
Name: top_simple_cpu

Overview:
Slice-based combinational ALU datapath with registered outputs. It is built from N_A identical S-bit slices, chained for carry, shift and compare. It executes one of four operations on unsigned operands A and B, selected by op, and presents RESULT and a 2-bit compare code one clock later. It sits as the execute stage of the simple slice CPU.

Parameters:
S, 4, bits per ALU slice (>=2)
N_A, 2, number of slices; datapath width W = N_A*S (default 8)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset
A  input  W  operand A, unsigned
B  input  W  operand B, unsigned
op  input  3  operation select
RESULT  output  W  registered result
CMP  output  2  registered compare code

Behaviour:
- One clock; reset is synchronous and active-low: on a rising clk edge with rst_n=0, RESULT<=0 and CMP<=2'b00. Reset takes priority over any op; the operation sampled in that cycle is discarded.
- Latency is exactly 1 cycle. A, B and op are sampled on each rising edge with rst_n=1. RESULT and CMP update on that same edge. There is no handshake; a new op is accepted every cycle.
- op=000 ADD: RESULT = (A+B) mod 2^W.
  - Ripple carry runs slice0 (LSBs) to slice N_A-1.
  - Carry-out is dropped, so 255+1 gives 0 at W=8.
  - CMP=00.
- op=001 SHR: RESULT = A >> 1, logical; MSB is filled with 0.
  - Each slice takes its top input bit from the next-higher slice's LSB; the top slice receives 0.
  - B is ignored; CMP=00.
- op=010 POPCNT: RESULT = number of 1 bits in A, zero-extended to W.
  - Per-slice counts are summed.
  - B is ignored; CMP=00.
- op=011 CMP: unsigned compare of A against B; RESULT=0.
  - CMP=00 if A==B.
  - CMP=01 if A>B.
  - CMP=10 if A<B.
  - 11 is never produced.
  - Compare is resolved from the most-significant slice downward: the first unequal slice decides.
- op=100..111: reserved; RESULT=0, CMP=00.
- Outputs hold their values between edges. All combinational paths are fully assigned, so no latches are inferred.

Optional Feature:
Macro TOP_SIMPLE_CPU_COUT_EN.
- When defined, adds output port COUT (1 bit, registered, reset to 0):
  - ADD: COUT = carry-out of the top slice.
  - SHR: COUT = the bit shifted out, A[0].
  - All other ops: COUT = 0.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with op=000, A=10, B=22 -> RESULT=0, CMP=00. Release reset -> RESULT=32 one edge later.
- ADD (W=8): A=10,B=22 -> 32. A=255,B=1 -> 0, and COUT=1 if enabled. A=100,B=50 -> 150. Each value appears exactly one edge after the inputs are applied.
- SHR: A=8'b10110011 -> 8'b01011001 (89). A=1 -> 0, and COUT=1 if enabled. B=0xFF does not change the result.
- POPCNT: A=0x00 -> 0. A=0xFF -> 8. A=8'b10101101 -> 5.
- CMP: A=50,B=50 -> 00. A=200,B=100 -> 01 (unsigned). A=10,B=20 -> 10. A=0x80,B=0x7F -> 01 (decided in the top slice). A=0x17,B=0x18 -> 10 (decided in the lower slice). RESULT=0 in every case.
- Back-to-back and reserved ops: change op every cycle through 000, 011, 010, 111 -> each output matches its op one cycle later. op=111 gives RESULT=0, CMP=00.
